irq_prio_ctrl: RTL and testbench



---
 rtl/irq_prio_ctrl.sv | 91 +++++++++
 tb/tb_irq_prio_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_ctrl.sv
// Interrupt front-end: pending capture, software mask, highest-index select,
// valid/ready delivery. Define IRQ_EDGE_EN to capture on rising edges of req.
module irq_prio_ctrl #(
   parameter int          N_REQ    = 16,
   parameter logic [15:0] MASK_RST = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             mask_we,
   input  logic [N_REQ-1:0] mask_wdata,
   output logic [N_REQ-1:0] mask,
   output logic [N_REQ-1:0] pending,
   output logic             V,
   output logic [3:0]       Q,
   input  logic             ready
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t           state;
   logic [N_REQ-1:0] set_vec;
   logic [N_REQ-1:0] clr_vec;
   logic [N_REQ-1:0] eff;
   logic [3:0]       sel_idx;

`ifdef IRQ_EDGE_EN
   logic [N_REQ-1:0] req_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) req_d <= '0;
      else        req_d <= req;
   end

   assign set_vec = req & ~req_d;
`else
   assign set_vec = req;
`endif

   assign eff = pending & mask;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (eff[i]) sel_idx = i[3:0];
      end
   end

   always_comb begin
      clr_vec = '0;
      if (V && ready) clr_vec[Q] = 1'b1;
   end

   // Clearing before OR-ing in the set vector makes a same-cycle set win over the accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         V       <= 1'b0;
         Q       <= '0;
         pending <= '0;
         mask    <= MASK_RST;
      end else begin
         pending <= (pending & ~clr_vec) | set_vec;
         if (mask_we) mask <= mask_wdata;
         case (state)
            IDLE: begin
               if (|eff) begin
                  Q     <= sel_idx;
                  V     <= 1'b1;
                  state <= PRESENT;
               end
            end
            PRESENT: begin
               if (ready) begin
                  V     <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               V     <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Self-checking bench for irq_prio_ctrl: directed scenarios plus random traffic,
// all compared each cycle against a behavioural model of the pending/priority rules.
module tb_irq_prio_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic        mask_we = 1'b0;
   logic [15:0] mask_wdata = '0;
   logic        ready = 1'b0;
   logic [15:0] mask;
   logic [15:0] pending;
   logic        V;
   logic [3:0]  Q;

   int total = 0;
   int bad   = 0;

   bit [15:0] m_pend, m_mask, m_req_d;
   bit        m_v;
   int        m_q;

   irq_prio_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .mask       (mask),
      .pending    (pending),
      .V          (V),
      .Q          (Q),
      .ready      (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend  = '0;
      m_mask  = 16'hFFFF;
      m_req_d = '0;
      m_v     = 1'b0;
      m_q     = 0;
   endtask

   // One rising edge worth of behaviour, computed from the documented rules.
   task automatic model_step(input bit [15:0] r, input bit we, input bit [15:0] wd, input bit rdy);
      bit        acc;
      bit [15:0] eff, setv;
      int        hi;
      acc = m_v && rdy;
      eff = m_pend & m_mask;
`ifdef IRQ_EDGE_EN
      setv = r & ~m_req_d;
`else
      setv = r;
`endif
      for (int i = 0; i < 16; i++) begin
         if (setv[i])              m_pend[i] = 1'b1;
         else if (acc && i == m_q) m_pend[i] = 1'b0;
      end
      if (!m_v) begin
         hi = -1;
         for (int i = 15; i >= 0; i--) begin
            if (hi < 0 && eff[i]) hi = i;
         end
         if (hi >= 0) begin
            m_v = 1'b1;
            m_q = hi;
         end
      end else if (acc) begin
         m_v = 1'b0;
      end
      if (we) m_mask = wd;
      m_req_d = r;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".pending"}, 32'(pending), 32'(m_pend));
      check({tag, ".mask"},    32'(mask),    32'(m_mask));
      check({tag, ".V"},       32'(V),       32'(m_v));
      check({tag, ".Q"},       32'(Q),       32'(m_q));
   endtask

   // Called just after a falling edge: drive, advance the model, sample at the next falling edge.
   task automatic cycle(input string tag, input bit [15:0] r, input bit we, input bit [15:0] wd, input bit rdy);
      req        = r;
      mask_we    = we;
      mask_wdata = wd;
      ready      = rdy;
      model_step(r, we, wd, rdy);
      @(posedge clk);
      @(negedge clk);
      compare_all(tag);
   endtask

   initial begin
      int nv;
      model_reset();

      // Reset then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      compare_all("rst");
      for (int i = 0; i < 10; i++) cycle("idle", '0, 1'b0, '0, 1'b0);
      check("idle_mask_ffff", 32'(mask), 32'h0000_FFFF);

      // Priority and latency
      cycle("prio_pulse", 16'h0104, 1'b0, '0, 1'b1);
      cycle("prio_sel8", '0, 1'b0, '0, 1'b1);
      check("prio_q8", 32'(Q), 32'h8);
      cycle("prio_acc8", '0, 1'b0, '0, 1'b1);
      cycle("prio_sel2", '0, 1'b0, '0, 1'b1);
      check("prio_q2", 32'(Q), 32'h2);
      cycle("prio_acc2", '0, 1'b0, '0, 1'b1);
      check("prio_drained", 32'({V, pending}), 32'h0);

      // Hold under backpressure
      cycle("bp_pulse", 16'h0008, 1'b0, '0, 1'b0);
      cycle("bp_sel3", '0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle("bp_hold", 16'h8000, 1'b0, '0, 1'b0);
         check("bp_q_stays3", 32'(Q), 32'h3);
      end
      cycle("bp_acc3", '0, 1'b0, '0, 1'b1);
      cycle("bp_sel15", '0, 1'b0, '0, 1'b0);
      check("bp_q15", 32'(Q), 32'hF);
      cycle("bp_acc15", '0, 1'b0, '0, 1'b1);

      // Masking
      cycle("msk_wr", '0, 1'b1, 16'h7FFF, 1'b0);
      cycle("msk_pulse", 16'h8001, 1'b0, '0, 1'b1);
      cycle("msk_sel0", '0, 1'b0, '0, 1'b1);
      check("msk_q0", 32'(Q), 32'h0);
      cycle("msk_acc0", '0, 1'b0, '0, 1'b1);
      cycle("msk_parked", '0, 1'b0, '0, 1'b1);
      check("msk_parked", 32'({V, pending}), 32'h8000);
      cycle("msk_unmask", '0, 1'b1, 16'hFFFF, 1'b0);
      cycle("msk_sel15", '0, 1'b0, '0, 1'b0);
      check("msk_q15", 32'({V, Q}), 32'h1F);
      cycle("msk_acc15", '0, 1'b0, '0, 1'b1);

      // Held request: level mode re-pends, edge mode fires once
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         cycle("hold5", 16'h0020, 1'b0, '0, 1'b1);
         if (V) nv++;
      end
`ifdef IRQ_EDGE_EN
      check("hold5_vectors", 32'(nv), 32'd1);
`else
      check("hold5_vectors", 32'(nv), 32'd4);
`endif
      for (int i = 0; i < 3; i++) cycle("hold5_drop", '0, 1'b0, '0, 1'b1);
      nv = 0;
      cycle("retoggle", 16'h0020, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle("retoggle_wait", '0, 1'b0, '0, 1'b1);
         if (V) nv++;
      end
      check("retoggle_vectors", 32'(nv), 32'd1);

      // Async reset mid-handshake
      cycle("ar_pulse", 16'h0200, 1'b0, '0, 1'b0);
      cycle("ar_sel9", '0, 1'b0, '0, 1'b0);
      check("ar_q9", 32'({V, Q}), 32'h19);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_v_async", 32'(V), 32'h0);
      check("ar_pend_async", 32'(pending), 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      compare_all("ar_release");
      for (int i = 0; i < 4; i++) cycle("ar_quiet", '0, 1'b0, '0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bit [15:0] r, wd;
         bit        we, rdy;
         r   = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
         we  = ($urandom_range(0, 15) == 0);
         wd  = 16'($urandom) | 16'($urandom);
         rdy = 1'($urandom_range(0, 1));
         cycle("rand", r, we, wd, rdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
